mem_arbiter: RTL and testbench

//  Shares one word-wide instruction/data memory port between the IF stage (read-only fetch)
//  and the MEM stage (load/store). It sequences a fixed-latency multi-cycle access per grant
//  and returns registered read data with a one-cycle ready pulse.
//  It sits between the pipeline (if/mem stages, stall logic) and the single unified RAM.

---
 rtl/mem_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbiter sharing one unified RAM port between instruction fetch and load/store.
// Each grant runs a fixed-latency access and returns registered data with a one-cycle ready pulse.
module mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ready,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [3:0]        mem_sel,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_ready,
   output logic              ram_ce,
   output logic              ram_we,
   output logic [3:0]        ram_sel,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   localparam logic [3:0] CNT_LAST = 4'(MEM_LAT - 1);

   state_t            state_q;
   logic [3:0]        cnt_q;
   logic              lastMem_q;
   logic              grantMem_q;
   logic              pickMem_d;
   logic [DATA_W-1:0] ifRdata_q;
   logic [DATA_W-1:0] memRdata_q;
   logic              ifReady_q;
   logic              memReady_q;
   logic              ramCe_q;
   logic              ramWe_q;
   logic [3:0]        ramSel_q;
   logic [ADDR_W-1:0] ramAddr_q;
   logic [DATA_W-1:0] ramWdata_q;
   logic              busy_q;

   // MEM normally wins a tie, but yields to IF right after its own grant so fetch never starves.
   always_comb begin
      pickMem_d = mem_req && (!if_req || !lastMem_q);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         lastMem_q  <= 1'b0;
         grantMem_q <= 1'b0;
         ifRdata_q  <= '0;
         memRdata_q <= '0;
         ifReady_q  <= 1'b0;
         memReady_q <= 1'b0;
         ramCe_q    <= 1'b0;
         ramWe_q    <= 1'b0;
         ramSel_q   <= '0;
         ramAddr_q  <= '0;
         ramWdata_q <= '0;
         busy_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (if_req || mem_req) begin
                  grantMem_q <= pickMem_d;
                  lastMem_q  <= pickMem_d;
                  ramCe_q    <= 1'b1;
                  cnt_q      <= '0;
                  busy_q     <= 1'b1;
                  state_q    <= ACCESS;
                  if (pickMem_d) begin
                     ramWe_q    <= mem_we;
                     ramSel_q   <= mem_sel;
                     ramAddr_q  <= mem_addr;
                     ramWdata_q <= mem_wdata;
                  end else begin
                     ramWe_q   <= 1'b0;
                     ramSel_q  <= 4'hF;
                     ramAddr_q <= if_addr;
                  end
               end
            end
            ACCESS: begin
               cnt_q <= cnt_q + 4'd1;
               if (cnt_q == CNT_LAST) begin
                  ramCe_q <= 1'b0;
                  ramWe_q <= 1'b0;
                  state_q <= DONE;
                  if (grantMem_q) begin
                     memReady_q <= 1'b1;
                     if (!ramWe_q) begin
                        memRdata_q <= ram_rdata;
                     end
                  end else begin
                     ifReady_q <= 1'b1;
                     ifRdata_q <= ram_rdata;
                  end
               end
            end
            DONE: begin
               ifReady_q  <= 1'b0;
               memReady_q <= 1'b0;
               busy_q     <= 1'b0;
               state_q    <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign if_rdata  = ifRdata_q;
   assign if_ready  = ifReady_q;
   assign mem_rdata = memRdata_q;
   assign mem_ready = memReady_q;
   assign ram_ce    = ramCe_q;
   assign ram_we    = ramWe_q;
   assign ram_sel   = ramSel_q;
   assign ram_addr  = ramAddr_q;
   assign ram_wdata = ramWdata_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: main latency-2 instance on a small byte-lane RAM model,
// plus latency-1 and latency-5 instances for timing.
module tb_mem_arbiter;

   typedef struct packed {
      logic        isMem;
      logic [31:0] data;
   } sbEntry_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        ifReq, memReq, memWe;
   logic [31:0] ifAddr, memAddr, memWdata;
   logic [3:0]  memSel;
   logic [31:0] ifRdata, memRdata, ramAddr, ramWdata, ramRdata;
   logic        ifReady, memReady, ramCe, ramWe, busy;
   logic [3:0]  ramSel;

   logic        l1Req, l5Req;
   logic [31:0] lAddr;
   logic [31:0] l1IfRdata, l1MemRdata, l1RamAddr, l1RamWdata, l1RamRdata;
   logic [31:0] l5IfRdata, l5MemRdata, l5RamAddr, l5RamWdata, l5RamRdata;
   logic        l1IfReady, l1MemReady, l1RamCe, l1RamWe, l1Busy;
   logic        l5IfReady, l5MemReady, l5RamCe, l5RamWe, l5Busy;
   logic [3:0]  l1RamSel, l5RamSel;

   logic [31:0] ram [0:255];
   sbEntry_t    sbQ[$];
   logic [31:0] expMemRdata;
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   logic [136:0] allOut;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut (
      .clk(clk), .rst(rst),
      .if_req(ifReq), .if_addr(ifAddr), .if_rdata(ifRdata), .if_ready(ifReady),
      .mem_req(memReq), .mem_we(memWe), .mem_sel(memSel), .mem_addr(memAddr),
      .mem_wdata(memWdata), .mem_rdata(memRdata), .mem_ready(memReady),
      .ram_ce(ramCe), .ram_we(ramWe), .ram_sel(ramSel), .ram_addr(ramAddr),
      .ram_wdata(ramWdata), .ram_rdata(ramRdata), .busy(busy)
   );

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dutLat1 (
      .clk(clk), .rst(rst),
      .if_req(l1Req), .if_addr(lAddr), .if_rdata(l1IfRdata), .if_ready(l1IfReady),
      .mem_req(1'b0), .mem_we(1'b0), .mem_sel(4'h0), .mem_addr(32'h0),
      .mem_wdata(32'h0), .mem_rdata(l1MemRdata), .mem_ready(l1MemReady),
      .ram_ce(l1RamCe), .ram_we(l1RamWe), .ram_sel(l1RamSel), .ram_addr(l1RamAddr),
      .ram_wdata(l1RamWdata), .ram_rdata(l1RamRdata), .busy(l1Busy)
   );

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(5)) dutLat5 (
      .clk(clk), .rst(rst),
      .if_req(l5Req), .if_addr(lAddr), .if_rdata(l5IfRdata), .if_ready(l5IfReady),
      .mem_req(1'b0), .mem_we(1'b0), .mem_sel(4'h0), .mem_addr(32'h0),
      .mem_wdata(32'h0), .mem_rdata(l5MemRdata), .mem_ready(l5MemReady),
      .ram_ce(l5RamCe), .ram_we(l5RamWe), .ram_sel(l5RamSel), .ram_addr(l5RamAddr),
      .ram_wdata(l5RamWdata), .ram_rdata(l5RamRdata), .busy(l5Busy)
   );

   assign allOut = {ramCe, ramWe, ramSel, ramAddr, ramWdata, ifRdata, memRdata,
                    ifReady, memReady, busy};
   assign ramRdata   = ram[ramAddr[9:2]];
   assign l1RamRdata = l1RamAddr ^ 32'hA5A5_0000;
   assign l5RamRdata = l5RamAddr ^ 32'hA5A5_0000;

   always @(posedge clk) cyc <= cyc + 1;

   // Byte-lane RAM model; a store lands on every cycle the RAM is enabled for write.
   always @(posedge clk) begin
      if (ramCe && ramWe) begin
         for (int b = 0; b < 4; b++) begin
            if (ramSel[b]) ram[ramAddr[9:2]][8*b +: 8] <= ramWdata[8*b +: 8];
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [159:0] got, input logic [159:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Completion monitor: every ready pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      sbEntry_t e;
      if (ifReady && memReady) checkOutput("both_ready", 1, 0);
      if (ifReady) begin
         if (sbQ.size() == 0) checkOutput("if_unexpected", 1, 0);
         else begin
            e = sbQ.pop_front();
            checkOutput("if_who", 0, e.isMem);
            checkOutput("if_rdata", ifRdata, e.data);
         end
      end
      if (memReady) begin
         if (sbQ.size() == 0) checkOutput("mem_unexpected", 1, 0);
         else begin
            e = sbQ.pop_front();
            checkOutput("mem_who", 1, e.isMem);
            checkOutput("mem_rdata", memRdata, e.data);
         end
      end
   end

   task automatic applyReset();
      @(posedge clk); #1;
      rst = 1'b0;
      ifReq = 1'b0;
      memReq = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("reset_outputs", allOut, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      expMemRdata = 32'h0;
   endtask

   // Called just after a rising edge; that cycle is cycle 0 of the access.
   task automatic applyStimulus(input bit isMem, input bit we, input logic [3:0] sel,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] expData);
      sbEntry_t e;
      if (isMem) begin
         memReq = 1'b1; memWe = we; memSel = sel; memAddr = addr; memWdata = wdata;
      end else begin
         ifReq = 1'b1; ifAddr = addr;
      end
      e.isMem = isMem;
      e.data  = (isMem && we) ? expMemRdata : expData;
      sbQ.push_back(e);
      if (isMem && !we) expMemRdata = expData;
      for (int c = 0; c <= 4; c++) begin
         @(negedge clk);
         checkOutput($sformatf("ram_ce_c%0d", c), ramCe, (c >= 1 && c <= 2));
         checkOutput($sformatf("busy_c%0d", c), busy, (c >= 1 && c <= 3));
         checkOutput($sformatf("ready_c%0d", c), isMem ? memReady : ifReady, (c == 3));
         if (c >= 1 && c <= 2) begin
            checkOutput("ram_addr", ramAddr, addr);
            checkOutput("ram_we", ramWe, (isMem && we));
            checkOutput("ram_sel", ramSel, isMem ? sel : 4'hF);
            if (isMem && we) checkOutput("ram_wdata", ramWdata, wdata);
         end
         if (c == 1) begin
            @(posedge clk); #1;
            if (isMem) begin
               memAddr = addr ^ 32'h0F0; memWdata = ~wdata;
            end else begin
               ifAddr = addr ^ 32'h0F0;
            end
         end
         if (c == 3) begin
            @(posedge clk); #1;
            ifReq = 1'b0;
            memReq = 1'b0;
         end
      end
   endtask

   initial begin
      #100000;
      bad++;
      $display("[TB] FAIL watchdog: got=timeout expected=finish");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      sbEntry_t e;
      int w;
      int lastCyc;
      for (int i = 0; i < 256; i++) ram[i] = 32'h0;
      ram[4]  = 32'h0051_3093;
      ram[16] = 32'h1111_1111;
      ram[17] = 32'h2222_2222;
      rst = 1'b0; ifReq = 1'b0; memReq = 1'b0; memWe = 1'b0; memSel = 4'h0;
      ifAddr = 32'h0; memAddr = 32'h0; memWdata = 32'h0;
      l1Req = 1'b0; l5Req = 1'b0; lAddr = 32'h0;
      expMemRdata = 32'h0;
      applyReset();

      $display("[TB] fetch only");
      applyStimulus(1'b0, 1'b0, 4'h0, 32'h0000_0010, 32'h0, 32'h0051_3093);

      $display("[TB] store then reload");
      @(posedge clk); #1;
      applyStimulus(1'b1, 1'b1, 4'b0011, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0);
      @(posedge clk); #1;
      applyStimulus(1'b1, 1'b0, 4'h0, 32'h0000_0100, 32'h0, 32'h0000_BEEF);

      $display("[TB] both requesters held");
      applyReset();
      ifReq = 1'b1; ifAddr = 32'h0000_0010;
      memReq = 1'b1; memWe = 1'b0; memAddr = 32'h0000_0100;
      for (int n = 0; n < 6; n++) begin
         e.isMem = (n % 2 == 0);
         e.data  = e.isMem ? 32'h0000_BEEF : 32'h0051_3093;
         sbQ.push_back(e);
      end
      expMemRdata = 32'h0000_BEEF;
      lastCyc = 0;
      for (int n = 0; n < 6; n++) begin
         w = 0;
         do begin
            @(negedge clk);
            w++;
         end while (!(ifReady || memReady) && w < 12);
         if (!(ifReady || memReady)) begin
            checkOutput("rr_timeout", w, 0);
         end else begin
            checkOutput("rr_order", memReady, (n % 2 == 0));
            if (n > 0) checkOutput("rr_spacing", cyc - lastCyc, 4);
            lastCyc = cyc;
         end
      end
      @(posedge clk); #1;
      ifReq = 1'b0; memReq = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      $display("[TB] reset during access");
      ifReq = 1'b1; ifAddr = 32'h0000_0010;
      @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("rst_pre_ce", ramCe, 1);
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("rst_mid_outputs", allOut, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      expMemRdata = 32'h0;
      applyStimulus(1'b0, 1'b0, 4'h0, 32'h0000_0010, 32'h0, 32'h0051_3093);

      $display("[TB] fetch arriving during a load");
      @(posedge clk); #1;
      memReq = 1'b1; memWe = 1'b0; memAddr = 32'h0000_0100;
      e.isMem = 1'b1; e.data = 32'h0000_BEEF; sbQ.push_back(e);
      expMemRdata = 32'h0000_BEEF;
      @(posedge clk); #1;
      ifReq = 1'b1; ifAddr = 32'h0000_0040;
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("late_ram_addr_mem", ramAddr, 32'h0000_0100);
      @(posedge clk); #1;
      ifAddr = 32'h0000_0044;
      @(negedge clk);
      checkOutput("late_mem_ready", memReady, 1);
      @(posedge clk); #1;
      memReq = 1'b0; ifAddr = 32'h0000_0010;
      e.isMem = 1'b0; e.data = 32'h0051_3093; sbQ.push_back(e);
      for (int c = 4; c <= 7; c++) begin
         @(negedge clk);
         checkOutput($sformatf("late_ce_c%0d", c), ramCe, (c == 5 || c == 6));
         checkOutput($sformatf("late_if_ready_c%0d", c), ifReady, (c == 7));
         if (c == 5) checkOutput("late_ram_addr_if", ramAddr, 32'h0000_0010);
         if (c == 5) ifAddr = 32'h0000_0044;
      end
      @(posedge clk); #1;
      ifReq = 1'b0;

      $display("[TB] latency 1 and 5 builds");
      applyReset();
      lAddr = 32'h0000_0200;
      l1Req = 1'b1; l5Req = 1'b1;
      for (int c = 0; c <= 8; c++) begin
         @(negedge clk);
         checkOutput($sformatf("l1_ce_c%0d", c), l1RamCe, (c == 1));
         checkOutput($sformatf("l1_ready_c%0d", c), l1IfReady, (c == 2));
         checkOutput($sformatf("l1_busy_c%0d", c), l1Busy, (c >= 1 && c <= 2));
         checkOutput($sformatf("l5_ce_c%0d", c), l5RamCe, (c >= 1 && c <= 5));
         checkOutput($sformatf("l5_ready_c%0d", c), l5IfReady, (c == 6));
         checkOutput($sformatf("l5_busy_c%0d", c), l5Busy, (c >= 1 && c <= 6));
         if (c == 2) begin
            checkOutput("l1_rdata", l1IfRdata, lAddr ^ 32'hA5A5_0000);
            @(posedge clk); #1;
            l1Req = 1'b0;
         end
         if (c == 6) begin
            checkOutput("l5_rdata", l5IfRdata, lAddr ^ 32'hA5A5_0000);
            @(posedge clk); #1;
            l5Req = 1'b0;
         end
      end

      repeat (2) @(negedge clk);
      checkOutput("sb_empty", sbQ.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
